// File: rtl/rstn_release_seq_if.sv
// Handshake and fabric-reset bundle for rstn_release_seq.
interface rstn_release_seq_if #(
  parameter int NUM_DOM = 20
);
  // sw_rst_req is a level; only its rising edge counts, and only when the
  // sequencer is in RELEASE/GAP/DONE. sw_rst_ack answers with a single-cycle
  // pulse once every domain is back in reset. A further request needs
  // sw_rst_req to return to 0 first.
  logic               sw_rst_req;
  logic               sw_rst_ack;
  logic [NUM_DOM-1:0] dom_mask;
  logic [NUM_DOM-1:0] rstn_out;
  logic               seq_busy;
  logic               seq_done;

  modport master (
    output sw_rst_req,
    output dom_mask,
    input  sw_rst_ack,
    input  rstn_out,
    input  seq_busy,
    input  seq_done
  );

  modport slave (
    input  sw_rst_req,
    input  dom_mask,
    output sw_rst_ack,
    output rstn_out,
    output seq_busy,
    output seq_done
  );
endinterface

// File: rtl/rstn_release_seq.sv
// Per-domain reset sequencer: async assert, ordered gapped release, sw re-reset.
// Define RSTN_SEQ_REV_ASSERT_EN to re-assert domains one by one in descending order.
module rstn_release_seq #(
  parameter int NUM_DOM     = 20,
  parameter int GAP_CYC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_0,
  input  logic              rstn_0,
  rstn_release_seq_if.slave bus,
  output logic [2:0]        dbg_state
);
  localparam int CNT_W = $clog2(GAP_CYC + 1);
  localparam int IDX_W = $clog2(NUM_DOM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GAP_CYC);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_GAP     = 3'd2,
    ST_DONE    = 3'd3,
    ST_ASSERT  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOM-1:0]     rstn_q, rstn_d;
  logic                   more_q, more_d;
  logic                   req_q;
  logic                   ack_q, ack_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   sync_ok, sync_next, req_rise, wait_done;
  logic                   do_rel, do_acc;
  logic                   found, more_after;
  logic [IDX_W-1:0]       rel_idx;
  logic [NUM_DOM-1:0]     rstn_rel, rstn_asrt;
`ifdef RSTN_SEQ_REV_ASSERT_EN
  logic                   asrt_hit;
`endif

  assign sync_ok   = sync_q[SYNC_STAGES-1];
  // Value sync_ok takes after this edge; lets seq_busy rise with the chain output.
  assign sync_next = sync_q[SYNC_STAGES-2];
  assign req_rise  = bus.sw_rst_req & ~req_q;
  assign wait_done = (cnt_q == CNT_LAST);
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Masked indices at or above idx_q are skipped in the same cycle; more_after
  // tells whether another unmasked domain is still waiting beyond this one.
  always_comb begin
    found      = 1'b0;
    more_after = 1'b0;
    rel_idx    = '0;
    rstn_rel   = rstn_q;
    for (int k = 0; k < NUM_DOM; k++) begin
      if ((IDX_W'(k) >= idx_q) && !bus.dom_mask[k]) begin
        if (!found) begin
          found       = 1'b1;
          rel_idx     = IDX_W'(k);
          rstn_rel[k] = 1'b1;
        end else begin
          more_after = 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef RSTN_SEQ_REV_ASSERT_EN
    rstn_asrt = rstn_q;
    asrt_hit  = 1'b0;
    for (int k = NUM_DOM - 1; k >= 0; k--) begin
      if (rstn_q[k] && !asrt_hit) begin
        rstn_asrt[k] = 1'b0;
        asrt_hit     = 1'b1;
      end
    end
`else
    rstn_asrt = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    more_d  = more_q;
    ack_d   = 1'b0;
    do_rel  = 1'b0;
    do_acc  = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (sync_ok) begin
          if (wait_done) do_rel = 1'b1;
          else           cnt_d  = cnt_inc;
        end
      end
      // RELEASE is the first cycle of the gap after each evaluation.
      ST_RELEASE, ST_GAP: begin
        if (req_rise)                              do_acc  = 1'b1;
        else if (state_q == ST_RELEASE && !more_q) state_d = ST_DONE;
        else if (wait_done)                        do_rel  = 1'b1;
        else begin
          cnt_d   = cnt_inc;
          state_d = ST_GAP;
        end
      end
      ST_DONE: begin
        if (req_rise) do_acc = 1'b1;
      end
      ST_ASSERT: begin
        if (!wait_done) begin
          cnt_d = cnt_inc;
        end else if (rstn_q != '0) begin
          rstn_d = rstn_asrt;
          cnt_d  = '0;
        end else begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_HOLD;
    endcase

    if (do_rel) begin
      rstn_d  = rstn_rel;
      idx_d   = found ? rel_idx + 1'b1 : idx_q;
      more_d  = more_after;
      cnt_d   = '0;
      state_d = ST_RELEASE;
    end
    // Acceptance outranks a release due on the same edge.
    if (do_acc) begin
      rstn_d  = rstn_asrt;
      cnt_d   = '0;
      state_d = ST_ASSERT;
    end

    busy_d = sync_next && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_0 or negedge rstn_0) begin
    if (!rstn_0) begin
      sync_q  <= '0;
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      more_q  <= 1'b0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      more_q  <= more_d;
      req_q   <= bus.sw_rst_req;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rstn_out   = rstn_q;
  assign bus.sw_rst_ack = ack_q;
  assign bus.seq_busy   = busy_q;
  assign bus.seq_done   = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_rstn_release_seq.sv
// Self-checking bench for rstn_release_seq (NUM_DOM=4, GAP_CYC=3, SYNC_STAGES=2).
module tb_rstn_release_seq;
  localparam int ND = 4;
  localparam int GC = 3;
  localparam int SS = 2;
  localparam int W  = ND + 3;

  // Power-up expectation: release edge per domain (0 = never) and seq_done edge.
  typedef struct packed {
    logic [ND-1:0]      mask;
    logic [ND-1:0][7:0] rel_e;
    logic [7:0]         done_e;
  } vec_t;

  logic       clk_0;
  logic       rstn_0;
  logic [2:0] dbg_state;
  int         checks;
  int         failures;
  logic [W-1:0] exp_q[$];
  vec_t       vecs [6];
  vec_t       v0;

  rstn_release_seq_if #(.NUM_DOM(ND)) bus ();

  rstn_release_seq #(
    .NUM_DOM    (ND),
    .GAP_CYC    (GC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_0    (clk_0),
    .rstn_0   (rstn_0),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end expected finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [ND-1:0] m, input int r0, input int r1,
                              input int r2, input int r3, input int d);
    vec_t v;
    v.mask     = m;
    v.rel_e[0] = 8'(r0);
    v.rel_e[1] = 8'(r1);
    v.rel_e[2] = 8'(r2);
    v.rel_e[3] = 8'(r3);
    v.done_e   = 8'(d);
    return v;
  endfunction

  // Expected {rstn_out, seq_busy, seq_done, sw_rst_ack} after edge n. For a sw
  // request n=1 is the accepting edge and pre holds the domains released then.
  function automatic logic [W-1:0] model(input vec_t v, input int n, input bit sw,
                                         input logic [ND-1:0] pre);
    int ack_at, off, busy_from, rel, de;
    int fall [ND];
    logic [ND-1:0] r;
    ack_at    = -100;
    off       = 0;
    busy_from = SS;
    for (int i = 0; i < ND; i++) fall[i] = 1;
    if (sw) begin
      busy_from = 1;
      ack_at    = 1 + GC;
`ifdef RSTN_SEQ_REV_ASSERT_EN
      begin
        int f;
        f = 0;
        for (int i = ND - 1; i >= 0; i--) begin
          if (pre[i]) begin
            fall[i] = 1 + GC * f;
            f++;
          end
        end
        if (f > 1) ack_at = 1 + GC * f;
      end
`endif
      off = ack_at + GC - (SS + GC);
    end
    de = int'(v.done_e) + off;
    for (int i = 0; i < ND; i++) begin
      rel  = int'(v.rel_e[i]);
      r[i] = ((rel != 0) && (n >= rel + off)) || (sw && pre[i] && (n < fall[i]));
    end
    return {r, (n >= busy_from) && (n < de), (n >= de), (n == ack_at)};
  endfunction

  function automatic logic [W-1:0] sample();
    return {bus.rstn_out, bus.seq_busy, bus.seq_done, bus.sw_rst_ack};
  endfunction

  // scoreboard
  task automatic compare_pop(input string tag, input int n);
    logic [W-1:0] e;
    logic [W-1:0] a;
    a = sample();
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s edge %0d: got %b required %b", tag, n, a, e);
    end
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    compare_pop(tag, 0);
  endtask

  // driver tasks
  task automatic run_check(input vec_t v, input int n_from, input int n_to,
                           input bit sw, input logic [ND-1:0] pre, input string tag);
    for (int n = n_from; n <= n_to; n++) begin
      exp_q.push_back(model(v, n, sw, pre));
      @(posedge clk_0);
      #1;
      compare_pop(tag, n);
    end
  endtask

  task automatic apply_reset(input logic [ND-1:0] mask);
    @(negedge clk_0);
    rstn_0         = 1'b0;
    bus.sw_rst_req = 1'b0;
    @(negedge clk_0);
    @(negedge clk_0);
    check_now("reset_state", '0);
    bus.dom_mask = mask;
    rstn_0       = 1'b1;
  endtask

  task automatic set_req(input logic val);
    @(negedge clk_0);
    bus.sw_rst_req = val;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rstn_0         = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.dom_mask   = '0;

    vecs[0] = mk(4'b0000, 5, 8, 11, 14, 15);
    vecs[1] = mk(4'b0010, 5, 0,  8, 11, 12);
    vecs[2] = mk(4'b1111, 0, 0,  0,  0,  6);
    vecs[3] = mk(4'b1001, 0, 5,  8,  0,  9);
    vecs[4] = mk(4'b0111, 0, 0,  0,  5,  6);
    vecs[5] = mk(4'b1110, 5, 0,  0,  0,  6);
    v0 = vecs[0];

    for (int t = 0; t < 6; t++) begin
      apply_reset(vecs[t].mask);
      run_check(vecs[t], 1, int'(vecs[t].done_e) + 2, 1'b0, '0, $sformatf("pwr_vec%0d", t));
    end
    checks++;
    if (dbg_state !== 3'd3) begin
      failures++;
      $display("FAIL fsm_done_state: got %0d required 3", dbg_state);
    end

    // Sub-cycle reset glitch after edge 9, then a full restart.
    apply_reset('0);
    run_check(v0, 1, 9, 1'b0, '0, "pre_glitch");
    #1 rstn_0 = 1'b0;
    #1 check_now("glitch_async", '0);
    #1 rstn_0 = 1'b1;
    run_check(v0, 1, 17, 1'b0, '0, "post_glitch");

    // Request from DONE, held high afterwards: exactly one re-reset.
    set_req(1'b1);
    run_check(v0, 1, 28, 1'b1, 4'b1111, "sw_done");
    set_req(1'b0);

    // Request rising into edge 9, mid-sequence.
    apply_reset('0);
    run_check(v0, 1, 8, 1'b0, '0, "mid_pre");
    set_req(1'b1);
    run_check(v0, 1, 28, 1'b1, 4'b0011, "sw_mid");
    set_req(1'b0);

    // Request on the same edge as the last release.
    apply_reset('0);
    run_check(v0, 1, 13, 1'b0, '0, "last_pre");
    set_req(1'b1);
    run_check(v0, 1, 28, 1'b1, 4'b0111, "sw_last");
    set_req(1'b0);

    // Rising edge seen during HOLD is ignored.
    apply_reset('0);
    run_check(v0, 1, 3, 1'b0, '0, "hold_pre");
    set_req(1'b1);
    run_check(v0, 4, 18, 1'b0, '0, "hold_ignore");
    set_req(1'b0);

    // Mask changed mid-sequence: bit 0 stays released, bit 2 now skipped.
    apply_reset('0);
    run_check(v0, 1, 9, 1'b0, '0, "mask_pre");
    @(negedge clk_0);
    bus.dom_mask = 4'b0101;
    run_check(mk(4'b0101, 5, 8, 0, 11, 12), 10, 14, 1'b0, '0, "mask_late");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
